// File: rtl/fp_pow2_pkg.sv
// Shared types and width/threshold helpers for the power-of-two float generator.
package fp_pow2_pkg;

  typedef enum logic [1:0] {CLS_NORM, CLS_SUB, CLS_OVF, CLS_UNF} pow2_cls_t;

  function automatic int bias(input int exp_bits);
    return (1 << (exp_bits - 1)) - 1;
  endfunction

  function automatic int fp_bits(input int exp_bits, input int man_bits);
    return 1 + exp_bits + man_bits;
  endfunction

  // Class bounds on the biased exponent e = a + BIAS: a > BIAS is e >= 2^EXP_BITS - 1.
  function automatic int e_ovf_min(input int exp_bits);
    return (1 << exp_bits) - 1;
  endfunction

  function automatic int e_norm_min();
    return 1;
  endfunction

  function automatic int e_sub_min(input int man_bits);
    return 1 - man_bits;
  endfunction

endpackage

// File: rtl/fp_two_int_power_pipe_if.sv
// Beat-level handshake bundle for fp_two_int_power_pipe; slave is the block's view.
interface fp_two_int_power_pipe_if
  import fp_pow2_pkg::*;
#(
  parameter int EXP_BITS = 5,
  parameter int MAN_BITS = 10,
  parameter int INT_BITS = 16,
  parameter int NCH      = 1
);
  localparam int FP_BITS = fp_bits(EXP_BITS, MAN_BITS);

  logic                    in_valid;
  logic                    in_ready;
  logic [NCH*INT_BITS-1:0] a;
  logic                    out_valid;
  logic                    out_ready;
  logic [NCH*FP_BITS-1:0]  c;
  logic [NCH-1:0]          ovf;
  logic [NCH-1:0]          unf;
  logic [NCH-1:0]          sub;

  modport master (output in_valid, a, out_ready,
                  input  in_ready, out_valid, c, ovf, unf, sub);
  modport slave  (input  in_valid, a, out_ready,
                  output in_ready, out_valid, c, ovf, unf, sub);
endinterface

// File: rtl/fp_pow2_lane.sv
// One lane of 2^a: S1 biases and classifies, S2 packs the float and flags.
// FP_TWO_POW_SUBNORMAL_EN enables subnormal outputs; otherwise they flush to +0.
module fp_pow2_lane
  import fp_pow2_pkg::*;
#(
  parameter int EXP_BITS = 5,
  parameter int MAN_BITS = 10,
  parameter int INT_BITS = 16,
  parameter int FP_BITS  = fp_bits(EXP_BITS, MAN_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en1,
  input  logic                en2,
  input  logic [INT_BITS-1:0] a,
  output logic [FP_BITS-1:0]  c,
  output logic                ovf,
  output logic                unf,
  output logic                sub
);
  typedef logic signed [INT_BITS:0] ext_t;

  localparam ext_t BIAS_X = ext_t'(bias(EXP_BITS));
  localparam ext_t E_OVF  = ext_t'(e_ovf_min(EXP_BITS));
  localparam ext_t E_NORM = ext_t'(e_norm_min());
`ifdef FP_TWO_POW_SUBNORMAL_EN
  localparam ext_t E_SUB   = ext_t'(e_sub_min(MAN_BITS));
  localparam int   EQ_BITS = INT_BITS + 1;
`else
  localparam int   EQ_BITS = EXP_BITS;
`endif

  ext_t             e;
  pow2_cls_t        cls;
  logic [EQ_BITS-1:0] e_q;
  pow2_cls_t        cls_q;

  // One extra bit of headroom means a + BIAS can never wrap.
  assign e = ext_t'({a[INT_BITS-1], a}) + BIAS_X;

  always_comb begin
    // NOTE: assigning a default before any branch keeps combinational blocks latch-free.
    cls = CLS_UNF;
    if (e >= E_OVF)       cls = CLS_OVF;
    else if (e >= E_NORM) cls = CLS_NORM;
`ifdef FP_TWO_POW_SUBNORMAL_EN
    else if (e >= E_SUB)  cls = CLS_SUB;
`endif
  end

  // NOTE: every register here is reset, including datapath, so outputs read 0 during rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      e_q   <= '0;
      cls_q <= CLS_UNF;
    end else if (en1) begin
      e_q   <= e[EQ_BITS-1:0];
      cls_q <= cls;
    end
  end

`ifdef FP_TWO_POW_SUBNORMAL_EN
  logic [EQ_BITS-1:0]  sh;
  logic [MAN_BITS-1:0] man_sub;
  assign sh      = e_q + EQ_BITS'(MAN_BITS - 1);
  assign man_sub = MAN_BITS'(1) << sh;
`endif

  logic [FP_BITS-1:0] c_d;
  logic               ovf_d, unf_d, sub_d;

  always_comb begin
    c_d   = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    sub_d = 1'b0;
    unique case (cls_q)
      CLS_NORM: c_d = {1'b0, e_q[EXP_BITS-1:0], {MAN_BITS{1'b0}}};
      CLS_OVF: begin
        c_d   = {1'b0, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
        ovf_d = 1'b1;
      end
`ifdef FP_TWO_POW_SUBNORMAL_EN
      CLS_SUB: begin
        c_d   = {1'b0, {EXP_BITS{1'b0}}, man_sub};
        sub_d = 1'b1;
      end
`endif
      default: unf_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c   <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      sub <= 1'b0;
    end else if (en2) begin
      c   <= c_d;
      ovf <= ovf_d;
      unf <= unf_d;
      sub <= sub_d;
    end
  end

endmodule

// File: rtl/fp_two_int_power_pipe.sv
// Multi-lane two-stage 2^a float generator with valid/ready backpressure.
// Subnormal generation is controlled by FP_TWO_POW_SUBNORMAL_EN inside fp_pow2_lane.
module fp_two_int_power_pipe
  import fp_pow2_pkg::*;
#(
  parameter int EXP_BITS = 5,
  parameter int MAN_BITS = 10,
  parameter int INT_BITS = 16,
  parameter int NCH      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  fp_two_int_power_pipe_if.slave  bus
);
  localparam int FP_BITS = fp_bits(EXP_BITS, MAN_BITS);

  logic s1_valid, s2_valid;
  logic en1, en2;

  // A stage may load when it is empty or its successor is draining it this cycle.
  assign en2           = !s2_valid || bus.out_ready;
  assign en1           = !s1_valid || en2;
  assign bus.in_ready  = en1;
  assign bus.out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (en1) s1_valid <= bus.in_valid;
      if (en2) s2_valid <= s1_valid;
    end
  end

  // Lane registers only move on real beats, so bubbles leave the outputs untouched.
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    fp_pow2_lane #(
      .EXP_BITS (EXP_BITS),
      .MAN_BITS (MAN_BITS),
      .INT_BITS (INT_BITS),
      .FP_BITS  (FP_BITS)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en1 (en1 && bus.in_valid),
      .en2 (en2 && s1_valid),
      .a   (bus.a[k*INT_BITS +: INT_BITS]),
      .c   (bus.c[k*FP_BITS +: FP_BITS]),
      .ovf (bus.ovf[k]),
      .unf (bus.unf[k]),
      .sub (bus.sub[k])
    );
  end

endmodule

// File: tb/tb_fp_two_int_power_pipe.sv
// Directed bench: half-precision single-lane and single-precision dual-lane instances.
module tb_fp_two_int_power_pipe;

`ifdef FP_TWO_POW_SUBNORMAL_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_two_int_power_pipe_if #(.EXP_BITS(5), .MAN_BITS(10), .INT_BITS(16), .NCH(1)) hb ();
  fp_two_int_power_pipe_if #(.EXP_BITS(8), .MAN_BITS(23), .INT_BITS(16), .NCH(2)) sb ();

  fp_two_int_power_pipe #(.EXP_BITS(5), .MAN_BITS(10), .INT_BITS(16), .NCH(1)) u_half (
    .clk (clk),
    .rst (rst),
    .bus (hb)
  );

  fp_two_int_power_pipe #(.EXP_BITS(8), .MAN_BITS(23), .INT_BITS(16), .NCH(2)) u_single (
    .clk (clk),
    .rst (rst),
    .bus (sb)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Half vectors: a, expected c, expected {ovf,unf,sub}.
  localparam int NH = 10;
  logic [15:0] h_a   [NH];
  logic [15:0] h_c   [NH];
  logic [2:0]  h_flg [NH];

  // Single dual-lane vectors: {lane1, lane0}.
  logic [31:0] s_a   [2];
  logic [63:0] s_c   [2];
  logic [5:0]  s_flg [2];  // {ovf[1:0], unf[1:0], sub[1:0]}

  logic [15:0] bp_a [6];
  logic [15:0] bp_c [6];
  bit          rdy_pat [8];

  initial begin
    h_a   = '{16'h0000, 16'h000F, 16'hFFF2, 16'h0001, 16'h0010,
              16'h7FFF, 16'h8000, 16'hFFF1, 16'hFFE8, 16'hFFE7};
    h_c   = '{16'h3C00, 16'h7800, 16'h0400, 16'h4000, 16'h7C00,
              16'h7C00, 16'h0000, SUB_EN ? 16'h0200 : 16'h0000,
              SUB_EN ? 16'h0001 : 16'h0000, 16'h0000};
    h_flg = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100,
              3'b100, 3'b010, SUB_EN ? 3'b001 : 3'b010,
              SUB_EN ? 3'b001 : 3'b010, 3'b010};

    s_a   = '{{16'd127, 16'hFF82}, {16'd128, 16'hFF6B}};
    s_c   = '{{32'h7F000000, 32'h00800000},
              {32'h7F800000, SUB_EN ? 32'h00000001 : 32'h00000000}};
    s_flg = '{6'b00_00_00, SUB_EN ? 6'b10_00_01 : 6'b10_01_00};

    bp_a    = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    bp_c    = '{16'h4400, 16'h4800, 16'h4C00, 16'h5000, 16'h5400, 16'h5800};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    hb.in_valid = 1'b0; hb.a = '0; hb.out_ready = 1'b1;
    sb.in_valid = 1'b0; sb.a = '0; sb.out_ready = 1'b1;
    #22 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_h_ovalid", hb.out_valid, 0);
    check("rst_h_c", hb.c, 0);
    check("rst_h_flags", {hb.ovf, hb.unf, hb.sub}, 0);
    check("rst_h_iready", hb.in_ready, 1);
    check("rst_s_ovalid", sb.out_valid, 0);
    check("rst_s_c", sb.c, 0);

    // Half stream, one beat per cycle, 2-cycle latency.
    for (int k = 0; k < NH + 2; k++) begin
      if (k == 1) check("h_lat_early", hb.out_valid, 0);
      if (k >= 2) begin
        check($sformatf("h_valid%0d", k - 2), hb.out_valid, 1);
        check($sformatf("h_c%0d", k - 2), hb.c, h_c[k-2]);
        check($sformatf("h_flg%0d", k - 2), {hb.ovf, hb.unf, hb.sub}, h_flg[k-2]);
      end
      if (k < NH) begin
        check($sformatf("h_iready%0d", k), hb.in_ready, 1);
        hb.in_valid = 1'b1;
        hb.a        = h_a[k];
      end else begin
        hb.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("h_drain", hb.out_valid, 0);

    // Single precision, two lanes.
    for (int k = 0; k < 4; k++) begin
      if (k >= 2) begin
        check($sformatf("s_valid%0d", k - 2), sb.out_valid, 1);
        check($sformatf("s_c%0d", k - 2), sb.c, s_c[k-2]);
        check($sformatf("s_flg%0d", k - 2), {sb.ovf, sb.unf, sb.sub}, s_flg[k-2]);
      end
      if (k < 2) begin
        sb.in_valid = 1'b1;
        sb.a        = s_a[k];
      end else begin
        sb.in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Backpressure: order, no loss/duplication, stability under stall.
    begin
      int          sent = 0;
      int          got = 0;
      int          outstanding = 0;
      logic        stall_prev = 1'b0;
      logic [15:0] c_prev = '0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
        hb.out_ready = rdy_pat[cyc % 8];
        hb.in_valid  = (sent < 6);
        hb.a         = bp_a[(sent < 6) ? sent : 5];
        #1;
        check("bp_iready", hb.in_ready, !(outstanding == 2 && !hb.out_ready));
        if (stall_prev) begin
          check("bp_hold_v", hb.out_valid, 1);
          check("bp_hold_c", hb.c, c_prev);
        end
        if (hb.out_valid && hb.out_ready) begin
          check($sformatf("bp_c%0d", got), hb.c, bp_c[got]);
          got++;
          outstanding--;
        end
        if (hb.in_valid && hb.in_ready) begin
          sent++;
          outstanding++;
        end
        stall_prev = hb.out_valid && !hb.out_ready;
        c_prev     = hb.c;
        @(negedge clk);
      end
      check("bp_count", got, 6);
      hb.in_valid  = 1'b0;
      hb.out_ready = 1'b1;
    end
    @(negedge clk);
    check("bp_empty", hb.out_valid, 0);

    // Mid-stream asynchronous reset with both stages full.
    hb.out_ready = 1'b0;
    hb.in_valid  = 1'b1;
    hb.a         = 16'd16;
    @(negedge clk);
    hb.a = 16'd1;
    @(negedge clk);
    hb.in_valid = 1'b0;
    check("full_iready", hb.in_ready, 0);
    check("full_ovalid", hb.out_valid, 1);
    check("full_ovf", hb.ovf, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_ovalid", hb.out_valid, 0);
    check("arst_c", hb.c, 0);
    check("arst_flags", {hb.ovf, hb.unf, hb.sub}, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    hb.out_ready = 1'b1;
    check("post_iready", hb.in_ready, 1);
    hb.in_valid = 1'b1;
    hb.a        = 16'd1;
    @(negedge clk);
    hb.in_valid = 1'b0;
    check("post_lat1", hb.out_valid, 0);
    @(negedge clk);
    check("post_lat2", hb.out_valid, 1);
    check("post_c", hb.c, 16'h4000);
    @(negedge clk);
    check("post_drain", hb.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_two_int_power_pipe.md
Name: fp_two_int_power_pipe

Overview:
- Multi-channel, pipelined generator of the IEEE-style float 2^a from a signed integer exponent a.
- Successor to the fixed half/single power-of-two wrappers: exponent and mantissa widths and channel count are parameters.
- Adds a valid/ready handshake with backpressure, overflow/underflow/subnormal flags and subnormal generation.
- Sits in the Precision library, ahead of scaling multipliers and normalisers.

Parameters:
- EXP_BITS, 5, exponent field width (5 = half, 8 = single); legal range 3..11.
- MAN_BITS, 10, stored mantissa width (10 = half, 23 = single); legal range 2..52.
- INT_BITS, 16, width of each signed two's-complement input exponent; must be >= EXP_BITS+1.
- NCH, 1, number of lanes sharing one handshake.
- Derived: FP_BITS = 1+EXP_BITS+MAN_BITS; BIAS = 2^(EXP_BITS-1)-1.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  NCH*INT_BITS  lane k occupies bits [k*INT_BITS +: INT_BITS]; signed.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the beat.
- c  out  NCH*FP_BITS  lane k result at [k*FP_BITS +: FP_BITS].
- ovf  out  NCH  per lane: a > BIAS, result is +inf.
- unf  out  NCH  per lane: result flushed to +0.
- sub  out  NCH  per lane: result is subnormal.

Behaviour:
- Reset: async on rst=1. s1_valid=0, s2_valid=0, out_valid=0, c=0, ovf=unf=sub=0. in_ready is 1 in the first cycle after reset is released.
- Pipeline: two register stages, S1 and S2.
  - en2 = !s2_valid | out_ready; en1 = !s1_valid | en2; in_ready = en1.
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Latency is 2 cycles from input transfer to out_valid with out_ready held at 1. Throughput is one beat per cycle.
  - When stalled (out_valid=1, out_ready=0), c, flags and out_valid hold stable. No beat is lost or duplicated. in_ready drops only once S1 and S2 are both full.
- S1 per lane:
  - e = a + BIAS, computed at INT_BITS+1 signed.
  - Classify into NORM, SUB, OVF or UNF (rules below) and register e and the class.
- S2 per lane: pack the result. Sign is always 0.
  - NORM, 1-BIAS <= a <= BIAS: exponent = e[EXP_BITS-1:0], mantissa = 0.
  - OVF, a > BIAS: exponent all ones, mantissa = 0, ovf=1.
  - SUB, 1-BIAS-MAN_BITS <= a <= -BIAS: exponent = 0, mantissa = 1 << (a+BIAS+MAN_BITS-1), sub=1.
  - UNF, a < 1-BIAS-MAN_BITS: all bits 0, unf=1.
- Boundaries:
  - a = most negative INT_BITS value gives UNF; a = most positive gives OVF. No wrap in the e computation.
  - Exactly one class holds per lane. Flags are mutually exclusive and are 0 for NORM.
- If in_valid is deasserted while in_ready=0, the beat is dropped by the source, not by the block. The block holds no partial state.
- Reset asserted mid-stream clears both stages immediately. Outputs go to 0 without waiting for a clock.

Optional Feature:
- Macro: FP_TWO_POW_SUBNORMAL_EN.
- Defined: SUB class is generated as described above.
- Undefined: every a < 1-BIAS maps to UNF (+0, unf=1), sub is tied to 0, and the subnormal shifter is removed.

Decomposition:
- Package fp_pow2_pkg:
  - enum pow2_cls_t {CLS_NORM, CLS_SUB, CLS_OVF, CLS_UNF}.
  - function bias(EXP_BITS).
  - function fp_bits(EXP_BITS, MAN_BITS).
  - localparam-style helpers for the class bounds.
- Sub-module fp_pow2_lane: per-lane S1 classify/add and S2 pack datapath. It takes en1/en2 and has no handshake logic. The top generates NCH lanes and owns the valid/ready control.

Test Plan:
1. Half defaults, NCH=1, out_ready=1: a = 0, 15, -14, 1 on consecutive cycles -> c = 0x3C00, 0x7800, 0x0400, 0x4000, each 2 cycles later; flags 0.
2. Half: a = 16 -> 0x7C00 with ovf=1; a = 32767 -> 0x7C00 with ovf=1; a = -32768 -> 0x0000 with unf=1.
3. Half, FP_TWO_POW_SUBNORMAL_EN defined: a = -15 -> 0x0200, sub=1; a = -24 -> 0x0001, sub=1; a = -25 -> 0x0000, unf=1. Undefined: a = -15 -> 0x0000, unf=1.
4. EXP_BITS=8, MAN_BITS=23, NCH=2: a = {127, -126} -> c = {0x7F000000, 0x00800000}; a = {128, -149} -> {0x7F800000 with ovf, 0x00000001 with sub}.
5. Backpressure: stream 6 beats while out_ready toggles 1,0,0,1,0,1,... -> in_ready=0 only when both stages are full; the output sequence equals the input order with no drops or duplicates; c is stable during stalls.
6. Reset: assert rst asynchronously between clock edges while both stages are full -> out_valid, c and flags are 0 immediately; after release, the first beat appears 2 cycles after acceptance.
